// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and coordinate/colour types for the VGA
// timing generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb3_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter plus
// registered sync and active flags computed from the next count value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE,
    parameter int unsigned FP     = H_FP,
    parameter int unsigned SYNC   = H_SYNC,
    parameter int unsigned BP     = H_BP
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   enable,
    output coord_t count,
    output coord_t count_next,
    output logic   wrap,
    output logic   sync_n,
    output logic   active
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST_C       = coord_t'(TOTAL - 1);
    localparam coord_t ACTIVE_C     = coord_t'(ACTIVE);
    localparam coord_t SYNC_START_C = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END_C   = coord_t'(ACTIVE + FP + SYNC);

    coord_t count_q, count_d;
    logic   sync_n_q, sync_n_d;
    logic   active_q, active_d;

    // Any value at or beyond the last position is a wrap point, so a corrupted
    // counter recovers on its next enabled cycle.
    always_comb begin
        wrap     = enable && (count_q >= LAST_C);
        count_d  = count_q;
        if (enable) begin
            count_d = (count_q >= LAST_C) ? '0 : count_q + coord_t'(1);
        end
        sync_n_d = !((count_d >= SYNC_START_C) && (count_d < SYNC_END_C));
        active_d = (count_d < ACTIVE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
            active_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
            active_q <= active_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign sync_n     = sync_n_q;
    assign active     = active_q;

endmodule

// File: rtl/hvsync_generator.sv
// 640x480@60 VGA timing generator with a registered colour-bar test pattern.
// Define HVSYNC_CHECKER_EN to overlay 32-line bands that invert the bar colours.
module hvsync_generator
    import vga_timing_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    output logic   vga_h_sync,
    output logic   vga_v_sync,
    output logic   inDisplayArea,
    output coord_t CounterX,
    output coord_t CounterY,
    output rgb3_t  pixel
);

    localparam coord_t H_ACTIVE_C = coord_t'(H_ACTIVE);
    localparam coord_t V_ACTIVE_C = coord_t'(V_ACTIVE);

    coord_t x_next, y_next;
    logic   h_wrap, v_wrap_unused;
    logic   h_active, v_active;
    rgb3_t  pixel_q, pixel_d;
    rgb3_t  pattern;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (1'b1),
        .count      (CounterX),
        .count_next (x_next),
        .wrap       (h_wrap),
        .sync_n     (vga_h_sync),
        .active     (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (h_wrap),
        .count      (CounterY),
        .count_next (y_next),
        .wrap       (v_wrap_unused),
        .sync_n     (vga_v_sync),
        .active     (v_active)
    );

    // Pattern is taken from the next coordinates so the registered pixel lines
    // up with the counter values it is presented alongside.
    always_comb begin
`ifdef HVSYNC_CHECKER_EN
        pattern = x_next[8:6] ^ {3{y_next[5]}};
`else
        pattern = x_next[8:6];
`endif
        pixel_d = '0;
        if ((x_next < H_ACTIVE_C) && (y_next < V_ACTIVE_C)) begin
            pixel_d = pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign inDisplayArea = h_active && v_active;
    assign pixel         = pixel_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench for hvsync_generator: expected output vectors are queued by
// the stimulus and compared by a separate negedge monitor.
module tb_hvsync_generator;

    logic       clk;
    logic       rst_n;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       inDisplayArea;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic [2:0] pixel;

    hvsync_generator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .inDisplayArea (inDisplayArea),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .pixel         (pixel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [25:0] exp_q[$];
    string       name_q[$];

    function automatic logic [25:0] vec(input logic hs, input logic vs, input logic de,
                                        input logic [9:0] x, input logic [9:0] y,
                                        input logic [2:0] p);
        return {hs, vs, de, x, y, p};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic push(input string name, input logic [25:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic force_line(input logic [9:0] y);
        force dut.u_v.count_q = y;
        #1;
        release dut.u_v.count_q;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [25:0] e;
            logic [25:0] o;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            o  = {vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY, pixel};
            n_checks++;
            if (o === e) n_pass++;
            else $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d px=%b expected hs=%b vs=%b de=%b x=%0d y=%0d px=%b",
                          nm, o[25], o[24], o[23], o[22:13], o[12:3], o[2:0],
                          e[25], e[24], e[23], e[22:13], e[12:3], e[2:0]);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int hs_low, hs_first, hs_last;
    int vs_low, vs_stray, de_bad;
    logic [2:0] band_px;

    initial begin
        hs_low = 0; hs_first = -1; hs_last = -1;
        vs_low = 0; vs_stray = 0; de_bad = 0;

        // reset
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        push("reset_state", vec(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b000));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        push("first_edge", vec(1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 3'b000));

        // horizontal line: X=2..799 then wrap to 0 with Y=1
        for (int k = 2; k <= 800; k++) begin
            tick();
            if (!vga_h_sync) begin
                hs_low++;
                if (hs_first < 0) hs_first = k % 800;
                hs_last = k % 800;
            end
            case (k)
                64:  push("x64_y0",   vec(1'b1, 1'b1, 1'b1, 10'd64,  10'd0, 3'b001));
                128: push("x128_y0",  vec(1'b1, 1'b1, 1'b1, 10'd128, 10'd0, 3'b010));
                639: push("x639",     vec(1'b1, 1'b1, 1'b1, 10'd639, 10'd0, 3'b001));
                640: push("x640",     vec(1'b1, 1'b1, 1'b0, 10'd640, 10'd0, 3'b000));
                655: push("x655",     vec(1'b1, 1'b1, 1'b0, 10'd655, 10'd0, 3'b000));
                656: push("x656",     vec(1'b0, 1'b1, 1'b0, 10'd656, 10'd0, 3'b000));
                751: push("x751",     vec(1'b0, 1'b1, 1'b0, 10'd751, 10'd0, 3'b000));
                752: push("x752",     vec(1'b1, 1'b1, 1'b0, 10'd752, 10'd0, 3'b000));
                799: push("x799",     vec(1'b1, 1'b1, 1'b0, 10'd799, 10'd0, 3'b000));
                800: push("h_wrap",   vec(1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 3'b000));
                default: ;
            endcase
        end
        check("hsync_low_cycles", hs_low, 96);
        check("hsync_first_x", hs_first, 656);
        check("hsync_last_x", hs_last, 751);

        // vertical: jump to line 479 at the end of line 1, then run to frame wrap
        repeat (799) tick();
        force_line(10'd478);
        for (int i = 0; i < 46 * 800; i++) begin
            int line;
            tick();
            line = 479 + i / 800;
            if (!vga_v_sync) begin
                vs_low++;
                if (line != 490 && line != 491) vs_stray++;
            end
            if (inDisplayArea && line >= 480) de_bad++;
            case (i)
                0:             push("y479_x0",   vec(1'b1, 1'b1, 1'b1, 10'd0,   10'd479, 3'b000));
                100:           push("y479_x100", vec(1'b1, 1'b1, 1'b1, 10'd100, 10'd479, 3'b001));
                800:           push("y480_x0",   vec(1'b1, 1'b1, 1'b0, 10'd0,   10'd480, 3'b000));
                11 * 800:      push("y490_x0",   vec(1'b1, 1'b0, 1'b0, 10'd0,   10'd490, 3'b000));
                12 * 800 + 799: push("y491_x799", vec(1'b1, 1'b0, 1'b0, 10'd799, 10'd491, 3'b000));
                13 * 800:      push("y492_x0",   vec(1'b1, 1'b1, 1'b0, 10'd0,   10'd492, 3'b000));
                45 * 800 + 700: push("y524_x700", vec(1'b0, 1'b1, 1'b0, 10'd700, 10'd524, 3'b000));
                45 * 800 + 799: push("y524_x799", vec(1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 3'b000));
                default: ;
            endcase
        end
        tick();
        push("frame_wrap", vec(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b000));
        check("vsync_low_cycles", vs_low, 1600);
        check("vsync_outside_490_491", vs_stray, 0);
        check("display_in_blank_lines", de_bad, 0);

        // band overlay at line 32
        repeat (799) tick();
        force_line(10'd31);
        repeat (65) tick();
`ifdef HVSYNC_CHECKER_EN
        band_px = 3'b110;
`else
        band_px = 3'b001;
`endif
        push("x64_y32", vec(1'b1, 1'b1, 1'b1, 10'd64, 10'd32, band_px));

        // mid-frame reset at X=300, Y=200
        repeat (735) tick();
        force_line(10'd199);
        repeat (300) tick();
        push("pre_reset_x299", vec(1'b1, 1'b1, 1'b1, 10'd299, 10'd200, 3'b100));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push("async_reset", vec(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 3'b000));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        push("restart_x1", vec(1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 3'b000));
        tick();
        push("restart_x2", vec(1'b1, 1'b1, 1'b1, 10'd2, 10'd0, 3'b000));

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
